bpu_binarize_pack: RTL and testbench
====================================

BPU_BINARIZE_PACK -- requirements
Module: bpu_binarize_pack

Interface
REQ-001 Parameter PSUM_W, default 7: width of the signed popcount sum received from the BPU.
REQ-002 Parameter PACK_W, default 7: number of activation bits packed into one output word.
REQ-003 Parameter DEPTH, default 4: output FIFO depth in words; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 psum_in  input  PSUM_W  signed accumulated popcount from the BPU.
REQ-007 psum_valid  input  1  psum_in is final for one output pixel; single-cycle qualifier.
REQ-008 thr_load  input  1  load thr_in and thr_inv into the threshold registers.
REQ-009 thr_in  input  PSUM_W  signed batch-norm threshold.
REQ-010 thr_inv  input  1  invert the comparison result (negative BN scale).
REQ-011 flush  input  1  emit the partially filled word (end of row or channel).
REQ-012 in_ready  output  1  block can accept psum_valid and flush this cycle.
REQ-013 out_data  output  PACK_W  head-of-FIFO packed activation word.
REQ-014 out_len  output  3  number of valid bits in out_data, 1..PACK_W.
REQ-015 out_valid  output  1  FIFO not empty.
REQ-016 out_ready  input  1  consumer accepts the head word.
REQ-017 err  output  1  sticky error: a psum_valid arrived while in_ready was low.

Function
REQ-018 Binarize: bit = (psum_in >= thr_reg, signed compare) XOR inv_reg.
REQ-019 thr_load SHALL update thr_reg and inv_reg at the clock edge. A psum_valid in the same cycle SHALL use the old values.
REQ-020 Packing: accepted bits SHALL fill the pack register LSB-first at index idx (0..PACK_W-1); idx SHALL then increment.
REQ-021 When a bit is written at idx == PACK_W-1, the full word SHALL be pushed with len = PACK_W, and idx and the pack register SHALL clear, in the same cycle.
REQ-022 Flush with idx > 0: the partial word SHALL be pushed, with upper bits zero and len = idx; idx SHALL clear.
REQ-023 Flush with idx == 0 and no bit accepted in the same cycle SHALL push nothing.
REQ-024 psum_valid and flush in the same cycle: the bit SHALL be included first.
  - If that bit completes the word, exactly one full word SHALL be pushed.
  - Otherwise one partial word SHALL be pushed, with len = idx+1.
REQ-025 Flush while FIFO full SHALL set flush_pend. in_ready SHALL be low while flush_pend is set. The pending flush SHALL execute in the first cycle the FIFO is not full; flush_pend SHALL then clear.
REQ-026 in_ready = !fifo_full && !flush_pend.
REQ-027 psum_valid with in_ready low:
  - the sample SHALL be dropped;
  - err SHALL be set;
  - idx SHALL be unchanged.
REQ-028 FIFO: a pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle SHALL both occur; the count is unchanged.
  - Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 A pop from a full FIFO in the same cycle as a pending flush SHALL allow the flush push that cycle.
REQ-030 out_data and out_len SHALL be registered FIFO head contents. Latency from the completing psum_valid to out_valid SHALL be 1 cycle when the FIFO is empty.
REQ-031 Popping an empty FIFO SHALL have no effect.

Reset
REQ-032 On rst, the following SHALL clear: idx, pack register, FIFO pointers/count, flush_pend, err. thr_reg and inv_reg SHALL be 0.
REQ-033 After rst: out_valid=0, out_data=0, out_len=0, in_ready=1, err=0.
REQ-034 rst mid-word SHALL discard the partial word and all FIFO contents; no word is emitted.

Verification
REQ-035 Full word:
  - Stimulus: thr=0, inv=0; 7 psum_valid with psums +3,-1,0,-7,5,-2,1.
  - Response: one word out_data=7'b1010101, out_len=7, out_valid high 1 cycle after the 7th input.
REQ-036 Inversion:
  - Stimulus: thr=2, inv=1, loaded in the same cycle as psum 2.
  - Response: that psum uses the old thr/inv. Later psums 2,1 yield bits 0,1.
REQ-037 Partial flush:
  - Stimulus: 3 bits 1,1,0, then flush.
  - Response: out_data=7'b0000011, out_len=3. A second flush emits nothing.
REQ-038 Flush with last bit:
  - Stimulus: psum_valid and flush together at idx=6.
  - Response: exactly one word, len=7.
  - Stimulus: the same at idx=2.
  - Response: one word, len=3.
REQ-039 Backpressure:
  - Stimulus: out_ready=0, fill 4 words, flush at idx=2, extra psum_valid.
  - Response: in_ready=0, err=1, sample dropped. After one pop, the pending word is pushed with len=2.
REQ-040 Reset with 2 words queued and idx=4 -> out_valid=0, in_ready=1, err=0; the next 7 bits form a fresh word.

Source files
------------

// File: rtl/bpu_binarize_pack.sv
// Binarizes BPU popcount sums against a batch-norm threshold and packs bits LSB-first into words.
// Latency: a word completed (or flushed) on one edge is visible at out_valid/out_data after that edge.
// Backpressure: in_ready drops when the output FIFO is full or a flush is pending; samples offered then are dropped and flagged in err.
module bpu_binarize_pack #(
  parameter int PSUM_W = 7,
  parameter int PACK_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  input  logic              thr_load,
  input  logic [PSUM_W-1:0] thr_in,
  input  logic              thr_inv,
  input  logic              flush,
  output logic              in_ready,
  output logic [PACK_W-1:0] out_data,
  output logic [2:0]        out_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  // out_len is three bits wide, so PACK_W is limited to 7; idx and lengths share that width.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0]       FULL_LEN = 3'(PACK_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Threshold state
  logic signed [PSUM_W-1:0] thr_reg;
  logic                     inv_reg;

  // Packing state
  logic [PACK_W-1:0] pack_reg;
  logic [2:0]        idx;
  logic              flush_pend;

  // FIFO state
  logic [PACK_W-1:0] mem_data [DEPTH];
  logic [2:0]        mem_len  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Combinational control
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;
  logic              flush_now;
  logic              pend_go;
  logic              pend_set;
  logic              bit_val;
  logic [PACK_W-1:0] pack_new;
  logic [2:0]        len_new;
  logic              push;
  logic [PACK_W-1:0] pack_next;
  logic [2:0]        idx_next;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full && !flush_pend;
  assign pop        = !fifo_empty && out_ready;
  assign accept     = psum_valid && in_ready;
  assign flush_now  = flush && in_ready;
  // A pending flush may go as soon as a slot exists, including the slot freed by a same-cycle pop.
  assign pend_go    = flush_pend && (!fifo_full || pop);
  // A flush that finds the FIFO full is remembered; repeats while pending merge into it.
  assign pend_set   = flush && fifo_full && !flush_pend;

  // Threshold compare uses the registered values, so a same-cycle thr_load affects only later samples.
  assign bit_val = ($signed(psum_in) >= thr_reg) ^ inv_reg;

  // Merge the incoming bit into the pack word and decide whether a word leaves this cycle.
  always_comb begin
    pack_new  = pack_reg;
    len_new   = idx;
    push      = 1'b0;
    pack_next = pack_reg;
    idx_next  = idx;
    if (accept) begin
      pack_new = pack_reg | (bit_val ? (PACK_W'(1) << idx) : '0);
      len_new  = idx + 3'd1;
    end
    pack_next = pack_new;
    idx_next  = len_new;
    // A full word or a flush of a non-empty word both emit exactly one word and restart packing.
    if ((len_new == FULL_LEN) || ((flush_now || pend_go) && (len_new != 3'd0))) begin
      push      = 1'b1;
      pack_next = '0;
      idx_next  = 3'd0;
    end
  end

  // Threshold registers load on thr_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_reg <= '0;
      inv_reg <= 1'b0;
    end else if (thr_load) begin
      thr_reg <= $signed(thr_in);
      inv_reg <= thr_inv;
    end
  end

  // Pack register, bit index and pending-flush flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg   <= '0;
      idx        <= 3'd0;
      flush_pend <= 1'b0;
    end else begin
      pack_reg <= pack_next;
      idx      <= idx_next;
      if (pend_go) begin
        flush_pend <= 1'b0;
      end else if (pend_set) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Sticky error for samples offered while the block could not take them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (psum_valid && !in_ready) begin
      err <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pack_new;
      mem_len[wr_ptr]  <= len_new;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of FIFO straight from registers; zeros while empty.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_data[rd_ptr];
  assign out_len   = fifo_empty ? 3'd0 : mem_len[rd_ptr];

endmodule

// File: tb/tb_bpu_binarize_pack.sv
// Directed bench for bpu_binarize_pack: expected words are queued at issue time, a monitor
// pops and compares them whenever the DUT hands a word over, and control outputs are checked
// directly at the points of interest.
module tb_bpu_binarize_pack;

  logic       clk;
  logic       rst;
  logic [6:0] psum_in;
  logic       psum_valid;
  logic       thr_load;
  logic [6:0] thr_in;
  logic       thr_inv;
  logic       flush;
  logic       in_ready;
  logic [6:0] out_data;
  logic [2:0] out_len;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  typedef struct {
    logic [6:0] d;
    logic [2:0] l;
  } word_t;

  word_t exp_q[$];
  int    n_cmp;
  int    n_bad;

  bpu_binarize_pack #(.PSUM_W(7), .PACK_W(7), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .thr_load   (thr_load),
    .thr_in     (thr_in),
    .thr_inv    (thr_inv),
    .flush      (flush),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_len    (out_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [6:0] d, input logic [2:0] l);
    word_t w;
    w.d = d;
    w.l = l;
    exp_q.push_back(w);
  endtask

  // One input cycle; all qualifiers return low afterwards. Returns #1 after the edge.
  task automatic drive(input bit v, input int p, input bit fl, input bit ld, input int t, input bit inv);
    psum_valid = v;
    psum_in    = 7'(p);
    flush      = fl;
    thr_load   = ld;
    thr_in     = 7'(t);
    thr_inv    = inv;
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
    flush      = 1'b0;
    thr_load   = 1'b0;
  endtask

  task automatic sample(input int p);
    drive(1'b1, p, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got data=%b len=%0d, required no word", out_data, out_len);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("word_data", int'(out_data), int'(w.d));
        check("word_len", int'(out_len), int'(w.l));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    psum_in    = '0;
    psum_valid = 1'b0;
    thr_load   = 1'b0;
    thr_in     = '0;
    thr_inv    = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_len", int'(out_len), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_err", int'(err), 0);

    // Full word, thr=0 inv=0: bits 1,0,1,0,1,0,1 LSB-first
    expect_word(7'b1010101, 3'd7);
    sample(3); sample(-1); sample(0); sample(-7); sample(5); sample(-2);
    check("full_no_early_word", int'(out_valid), 0);
    sample(1);
    check("full_latency_valid", int'(out_valid), 1);
    idle();

    // Threshold loaded with a psum: that psum still sees thr=0/inv=0 -> 1; then 2 -> 0, 1 -> 1
    expect_word(7'b0000101, 3'd3);
    drive(1'b1, 2, 1'b0, 1'b1, 2, 1'b1);
    sample(2); sample(1);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    idle();

    // Partial flush of 1,1,0 then a second flush that emits nothing
    expect_word(7'b0000011, 3'd3);
    sample(1); sample(1); sample(-1);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    check("second_flush_empty", int'(out_valid), 0);
    idle();

    // Flush together with the bit at idx=6: exactly one full word
    expect_word(7'b1010101, 3'd7);
    sample(1); sample(-1); sample(1); sample(-1); sample(1); sample(-1);
    drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    check("flush_last_valid", int'(out_valid), 1);
    idle();
    check("flush_last_single", int'(out_valid), 0);

    // Flush together with the bit at idx=2: bits 0,1,1 -> len 3
    expect_word(7'b0000110, 3'd3);
    sample(-1); sample(1);
    drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    idle();

    // Backpressure: four words held in the FIFO
    out_ready = 1'b0;
    expect_word(7'b0000001, 3'd1);
    drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    expect_word(7'b0000000, 3'd2);
    sample(-1);
    drive(1'b1, -1, 1'b1, 1'b0, 0, 1'b0);
    expect_word(7'b0000101, 3'd3);
    sample(1); sample(-1);
    drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    expect_word(7'b1111111, 3'd7);
    for (int i = 0; i < 7; i++) sample(0);
    check("full_in_ready", int'(in_ready), 0);
    check("full_no_err", int'(err), 0);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    check("pend_in_ready", int'(in_ready), 0);
    sample(5);
    check("drop_err", int'(err), 1);
    // One pop while the flush is pending frees the slot and releases the pending flush
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("pend_released_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    // Dropped sample must not have advanced idx: 1,0 then flush -> len 2
    expect_word(7'b0000001, 3'd2);
    sample(1); sample(-1);
    drive(1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
    check("err_sticky", int'(err), 1);
    repeat (6) idle();

    // Reset with two words queued and idx=4
    out_ready = 1'b0;
    drive(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, -1, 1'b1, 1'b0, 0, 1'b0);
    sample(1); sample(1); sample(1); sample(1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_err", int'(err), 0);
    out_ready = 1'b1;
    expect_word(7'b0101010, 3'd7);
    sample(-1); sample(1); sample(-1); sample(1); sample(-1); sample(1); sample(-1);

    // Drain with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_left", exp_q.size(), 0);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
